// File: rtl/tiny45_mem_pkg.sv
// Shared definitions for the Tiny45 load/store path: FSM states, mem_op size codes,
// default QPI command bytes and the access-size / load-extension helpers.
package tiny45_mem_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_STORE_CAP,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RDATA,
    S_WDATA,
    S_DESEL,
    S_RESP
  } state_e;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  localparam logic [7:0] QPI_READ_CMD  = 8'hEB;
  localparam logic [7:0] QPI_WRITE_CMD = 8'h38;

  // Size code 3 is treated as a word access.
  function automatic logic [2:0] nbytes(input logic [2:0] mem_op);
    case (mem_op[1:0])
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] mem_op);
    logic fill;
    fill = 1'b0;
    case (mem_op[1:0])
      MEM_BYTE: begin
        fill = ~mem_op[2] & w[7];
        return {{24{fill}}, w[7:0]};
      end
      MEM_HALF: begin
        fill = ~mem_op[2] & w[15];
        return {{16{fill}}, w[15:0]};
      end
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/tiny45_qspi_mem_if.sv
// Core-side request/response signals plus the QPI device pins of the memory responder.
interface tiny45_qspi_mem_if;
  logic [23:0] addr;
  logic [2:0]  mem_op;
  logic        start_read;
  logic        start_write;
  logic [2:0]  counter;
  logic [3:0]  store_data;
  logic [3:0]  data_out;
  logic        load_data_ready;
  logic        busy;
  logic        spi_cs_n;
  logic        spi_clk;
  logic [3:0]  spi_data_out;
  logic        spi_data_oe;
  logic [3:0]  spi_data_in;

  modport slave (
    input  addr, mem_op, start_read, start_write, counter, store_data, spi_data_in,
    output data_out, load_data_ready, busy, spi_cs_n, spi_clk, spi_data_out, spi_data_oe
  );

  modport master (
    output addr, mem_op, start_read, start_write, counter, store_data, spi_data_in,
    input  data_out, load_data_ready, busy, spi_cs_n, spi_clk, spi_data_out, spi_data_oe
  );
endinterface

// File: rtl/tiny45_qspi_nibble.sv
// Two-clock nibble timer: spi_clk phase and nibble index within the current FSM state.
// The index restarts whenever the last nibble of a state ends or the bus goes idle.
module tiny45_qspi_nibble #(
  parameter int unsigned NW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          run_i,
  input  logic          last_i,
  output logic          spi_clk_o,
  output logic          nib_end_o,
  output logic [NW-1:0] nib_o
);

  logic          ph_q;
  logic [NW-1:0] nib_q;

  always_ff @(posedge clk) begin
    if (!rstn || !run_i) begin
      ph_q  <= 1'b0;
      nib_q <= '0;
    end else begin
      ph_q <= ~ph_q;
      if (ph_q) nib_q <= last_i ? '0 : nib_q + NW'(1);
    end
  end

  // Second clock of a nibble: spi_clk high, device data is taken at its closing edge.
  assign spi_clk_o = ph_q & run_i;
  assign nib_end_o = ph_q & run_i;
  assign nib_o     = nib_q;

endmodule

// File: rtl/tiny45_qspi_mem.sv
// Tiny45 memory responder: turns core load/store requests into QPI transactions and
// replays load results to the core as 8 nibbles aligned to counter==0.
module tiny45_qspi_mem
  import tiny45_mem_pkg::*;
#(
  parameter int unsigned DUMMY_NIBBLES = 6,
  parameter logic [7:0]  READ_CMD      = QPI_READ_CMD,
  parameter logic [7:0]  WRITE_CMD     = QPI_WRITE_CMD
) (
  input  logic             clk,
  input  logic             rstn,
  tiny45_qspi_mem_if.slave bus
);

  localparam int unsigned NW = 5;

  state_e        state_q, state_d;
  logic          wr_q, wr_d;
  logic [23:0]   addr_q, addr_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   word_q, word_d;
  logic [2:0]    cyc_q, cyc_d;

  logic          run, nib_end, nib_last, spi_clk, rdy;
  logic [NW-1:0] nib, nib_len;
  logic [7:0]    cmd_byte;
  logic [4:0]    addr_lsb, word_lsb;
  logic [3:0]    tx_nib;

  assign run = state_q inside {S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA};

  always_comb begin
    nib_len = NW'(2);
    case (state_q)
      S_ADDR:           nib_len = NW'(6);
      S_DUMMY:          nib_len = NW'(DUMMY_NIBBLES);
      S_RDATA, S_WDATA: nib_len = NW'({nbytes(op_q), 1'b0});
      default:          ;
    endcase
  end

  assign nib_last = (nib == nib_len - NW'(1));

  tiny45_qspi_nibble #(.NW(NW)) u_nib (
    .clk       (clk),
    .rstn      (rstn),
    .run_i     (run),
    .last_i    (nib_last),
    .spi_clk_o (spi_clk),
    .nib_end_o (nib_end),
    .nib_o     (nib)
  );

  // Wire nibble n is byte n/2, high half first, so its word position is n^1.
  assign word_lsb = {nib[2:0] ^ 3'd1, 2'b00};
  assign addr_lsb = 5'd20 - {nib[2:0], 2'b00};
  assign cmd_byte = wr_q ? WRITE_CMD : READ_CMD;

  always_comb begin
    tx_nib = 4'h0;
    case (state_q)
      S_CMD:   tx_nib = nib[0] ? cmd_byte[3:0] : cmd_byte[7:4];
      S_ADDR:  tx_nib = addr_q[addr_lsb +: 4];
      S_WDATA: tx_nib = word_q[word_lsb +: 4];
      default: ;
    endcase
  end

  // Response waits in RESP until the core's counter wraps to 0, then streams 8 nibbles.
  assign rdy = (state_q == S_RESP) && (cyc_q != 3'd0 || bus.counter == 3'd0);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    op_d    = op_q;
    word_d  = word_q;
    cyc_d   = cyc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_write) begin
          state_d = S_STORE_CAP;
          wr_d    = 1'b1;
          addr_d  = bus.addr;
          op_d    = bus.mem_op;
          cyc_d   = 3'd0;
        end else if (bus.start_read) begin
          state_d = S_CMD;
          wr_d    = 1'b0;
          addr_d  = bus.addr;
          op_d    = bus.mem_op;
          word_d  = '0;
        end
      end
      S_STORE_CAP: begin
        word_d[{cyc_q, 2'b00} +: 4] = bus.store_data;
        cyc_d = cyc_q + 3'd1;
        if (cyc_q == 3'd7) state_d = S_CMD;
      end
      S_CMD:   if (nib_end && nib_last) state_d = S_ADDR;
      S_ADDR:  if (nib_end && nib_last) state_d = wr_q ? S_WDATA : S_DUMMY;
      S_DUMMY: if (nib_end && nib_last) state_d = S_RDATA;
      S_RDATA: begin
        if (nib_end) word_d[word_lsb +: 4] = bus.spi_data_in;
        if (nib_end && nib_last) state_d = S_DESEL;
      end
      S_WDATA: if (nib_end && nib_last) state_d = S_DESEL;
      S_DESEL: begin
        cyc_d = cyc_q + 3'd1;
        if (cyc_q == 3'd1) begin
          cyc_d = 3'd0;
          if (wr_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
            word_d  = load_extend(word_q, op_q);
          end
        end
      end
      S_RESP: begin
        if (rdy) begin
          cyc_d = cyc_q + 3'd1;
          if (cyc_q == 3'd7) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      op_q    <= '0;
      word_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      word_q  <= word_d;
      cyc_q   <= cyc_d;
    end
  end

  assign bus.busy            = (state_q != S_IDLE);
  assign bus.spi_cs_n        = ~run;
  assign bus.spi_clk         = spi_clk;
  assign bus.spi_data_oe     = state_q inside {S_CMD, S_ADDR, S_WDATA};
  assign bus.spi_data_out    = tx_nib;
  assign bus.load_data_ready = rdy;
  assign bus.data_out        = rdy ? word_q[{cyc_q, 2'b00} +: 4] : 4'h0;

endmodule

// File: tb/tb_tiny45_qspi_mem.sv
// Bench: behavioural QPI RAM on the device pins, free-running core counter, table and random ops.
module tb_tiny45_qspi_mem;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  tiny45_qspi_mem_if mi();

  tiny45_qspi_mem #(.DUMMY_NIBBLES(6), .READ_CMD(8'hEB), .WRITE_CMD(8'h38)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (mi)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [2:0] ctr = 3'd0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    ctr = ctr + 3'd1;
  end
  assign mi.counter = ctr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic int nb_of(input logic [2:0] op);
    return (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
  endfunction

  // ---------------- behavioural QPI RAM ----------------
  logic [7:0]  dev_mem [0:4095];
  logic [7:0]  ref_mem [0:4095];
  int          dnib = 0;
  int          tot_nib = 0;
  int          txn_cnt = 0;
  logic [7:0]  dcmd = 8'h00;
  logic [23:0] dadr = 24'h0;
  logic        prev_cs = 1'b1;
  logic [7:0]  db;
  logic [11:0] dix;
  logic [3:0]  wire_q[$];

  always @(negedge clk) begin
    if (mi.spi_cs_n) begin
      if (!prev_cs) txn_cnt++;
      dnib = 0;
      mi.spi_data_in = 4'h0;
    end else if (!mi.spi_clk) begin
      if (dcmd == 8'hEB && dnib >= 14) begin
        dix = dadr[11:0] + 12'((dnib - 14) / 2);
        db  = dev_mem[dix];
        mi.spi_data_in = ((dnib - 14) % 2 == 0) ? db[7:4] : db[3:0];
      end
    end else begin
      tot_nib++;
      if (mi.spi_data_oe) wire_q.push_back(mi.spi_data_out);
      if (dnib < 2) dcmd = {dcmd[3:0], mi.spi_data_out};
      else if (dnib < 8) dadr = {dadr[19:0], mi.spi_data_out};
      else if (dcmd == 8'h38) begin
        dix = dadr[11:0] + 12'((dnib - 8) / 2);
        if ((dnib - 8) % 2 == 0) dev_mem[dix][7:4] = mi.spi_data_out;
        else dev_mem[dix][3:0] = mi.spi_data_out;
      end
      dnib++;
    end
    prev_cs = mi.spi_cs_n;
  end

  // ---------------- core-side monitor ----------------
  bit          mon_on = 1'b0;
  int          t0, mk, first_cs, last_cs, first_rdy, rdy_cnt, last_busy, first_busy, exp_rdy, exp_rdy_min;
  bit          rdy_gap;
  logic [31:0] resp;

  always @(negedge clk) if (mon_on) begin
    mk = cyc - t0;
    if (!mi.spi_cs_n) begin
      if (first_cs < 0) first_cs = mk;
      last_cs = mk;
    end
    if (mi.busy) begin
      if (first_busy < 0) first_busy = mk;
      last_busy = mk;
    end
    if (exp_rdy < 0 && mk >= exp_rdy_min && ctr == 3'd0) exp_rdy = mk;
    if (mi.load_data_ready) begin
      if (first_rdy < 0) first_rdy = mk;
      if (mk != first_rdy + rdy_cnt) rdy_gap = 1'b1;
      if (rdy_cnt < 8) resp[4*rdy_cnt +: 4] = mi.data_out;
      rdy_cnt++;
    end
  end

  function automatic logic [31:0] model_load(input logic [23:0] a, input logic [2:0] op);
    int nb;
    logic [31:0] v;
    nb = nb_of(op);
    v  = 32'h0;
    for (int i = 0; i < nb; i++) v |= 32'(ref_mem[a[11:0] + 12'(i)]) << (8 * i);
    if (nb < 4 && !op[2] && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
    return v;
  endfunction

  // One request; start_cnt>=0 waits for that counter value, inj>0 pulses start_read on that clock.
  task automatic run_op(input bit wr, input logic [23:0] a, input logic [2:0] op, input logic [31:0] wd,
                        input int start_cnt, input int inj, output logic [31:0] got);
    int nb, exp_last, guard, mism, txn0;
    logic [3:0] ew[$];
    logic [7:0] cb;
    nb = nb_of(op);
    cb = wr ? 8'h38 : 8'hEB;
    ew.push_back(cb[7:4]);
    ew.push_back(cb[3:0]);
    for (int i = 5; i >= 0; i--) ew.push_back(a[4*i +: 4]);
    if (wr) for (int i = 0; i < nb; i++) begin
      ew.push_back(wd[8*i+4 +: 4]);
      ew.push_back(wd[8*i +: 4]);
    end
    exp_last = wr ? 24 + 4*nb : 28 + 4*nb;
    guard = 0;
    do begin
      @(posedge clk); #2;
      guard++;
    end while (start_cnt >= 0 && ctr != 3'(start_cnt) && guard < 16);
    wire_q.delete();
    tot_nib = 0; txn0 = txn_cnt;
    first_cs = -1; last_cs = -1; first_rdy = -1; rdy_cnt = 0; rdy_gap = 1'b0; resp = 32'h0;
    last_busy = -1; first_busy = -1; exp_rdy = -1; exp_rdy_min = exp_last + 3;
    t0 = cyc; mon_on = 1'b1;
    mi.addr = a; mi.mem_op = op;
    if (wr) mi.start_write = 1'b1; else mi.start_read = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #2;
      mi.start_write = 1'b0;
      mi.start_read  = (k == inj);
      mi.addr        = a ^ 24'h000FF0;
      mi.mem_op      = ~op;
      if (k <= 8) mi.store_data = wd[4*(k-1) +: 4];
    end
    guard = 0;
    while (mi.busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    mon_on = 1'b0;
    check("timeout", 32'(guard < 200), 32'd1);
    got = resp;
    mism = 0;
    for (int i = 0; i < ew.size() && i < wire_q.size(); i++) if (wire_q[i] !== ew[i]) mism++;
    check("wire_len", wire_q.size(), ew.size());
    check("wire_seq", mism, 0);
    check("nibbles", tot_nib, 8 + (wr ? 0 : 6) + 2*nb);
    check("cs_first", first_cs, wr ? 9 : 1);
    check("cs_last", last_cs, exp_last);
    check("busy_first", first_busy, 1);
    check("busy_last", last_busy, wr ? exp_last + 2 : exp_rdy + 7);
    check("txn", txn_cnt - txn0, 1);
    check("rdy_cnt", rdy_cnt, wr ? 0 : 8);
    if (!wr) begin
      check("rdy_first", first_rdy, exp_rdy);
      check("rdy_gap", 32'(rdy_gap), 32'd0);
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[a[11:0] + 12'(i)] = wd[8*i +: 8];
      mism = 0;
      for (int i = -1; i <= nb; i++) if (dev_mem[a[11:0] + 12'(i)] !== ref_mem[a[11:0] + 12'(i)]) mism++;
      check("store_mem", mism, 0);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [23:0] a;
    logic [2:0]  op;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] got, exp;
    bit          wr;
    logic [23:0] a;
    logic [2:0]  op;
    logic [31:0] wd;

    vecs[0] = '{1'b0, 24'h000104, 3'd2, 32'h0,         32'h12345678};
    vecs[1] = '{1'b0, 24'h000200, 3'd0, 32'h0,         32'hFFFFFF9A};
    vecs[2] = '{1'b0, 24'h000200, 3'd4, 32'h0,         32'h0000009A};
    vecs[3] = '{1'b1, 24'h000300, 3'd1, 32'h00001234,  32'h0};
    vecs[4] = '{1'b0, 24'h000300, 3'd5, 32'h0,         32'h00001234};
    vecs[5] = '{1'b1, 24'h000400, 3'd2, 32'hDEADBEEF,  32'h0};
    vecs[6] = '{1'b0, 24'h000402, 3'd1, 32'h0,         32'hFFFFDEAD};
    vecs[7] = '{1'b0, 24'h000401, 3'd4, 32'h0,         32'h000000BE};
    vecs[8] = '{1'b0, 24'h000400, 3'd3, 32'h0,         32'hDEADBEEF};

    for (int i = 0; i < 4096; i++) begin
      dev_mem[i] = 8'(i * 37 + 5);
      ref_mem[i] = 8'(i * 37 + 5);
    end
    dev_mem[12'h104] = 8'h78; dev_mem[12'h105] = 8'h56; dev_mem[12'h106] = 8'h34; dev_mem[12'h107] = 8'h12;
    ref_mem[12'h104] = 8'h78; ref_mem[12'h105] = 8'h56; ref_mem[12'h106] = 8'h34; ref_mem[12'h107] = 8'h12;
    dev_mem[12'h200] = 8'h9A; ref_mem[12'h200] = 8'h9A;

    mi.addr = 24'h0; mi.mem_op = 3'd0; mi.start_read = 1'b0; mi.start_write = 1'b0; mi.store_data = 4'h0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", 32'(mi.spi_cs_n), 32'd1);
    check("rst_spi_clk", 32'(mi.spi_clk), 32'd0);
    check("rst_oe", 32'(mi.spi_data_oe), 32'd0);
    check("rst_data_out", 32'(mi.data_out), 32'd0);
    check("rst_ready", 32'(mi.load_data_ready), 32'd0);
    check("rst_busy", 32'(mi.busy), 32'd0);
    @(posedge clk); #2;
    rstn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].wr, vecs[i].a, vecs[i].op, vecs[i].wd, -1, 0, got);
      if (!vecs[i].wr) check($sformatf("vec%0d_load", i), got, vecs[i].exp);
    end

    // Word load where the response phase opens at counter==3.
    run_op(1'b0, 24'h000104, 3'd2, 32'h0, 4, 0, got);
    check("late_load", got, 32'h12345678);
    check("late_rdy_first", first_rdy, 52);

    // start_read during a store's capture phase must be ignored.
    run_op(1'b1, 24'h000500, 3'd2, 32'hCAFEF00D, -1, 3, got);
    run_op(1'b0, 24'h000500, 3'd2, 32'h0, -1, 0, got);
    check("ignored_start_load", got, 32'hCAFEF00D);

    // Reset while the address is on the wire.
    @(posedge clk); #2;
    mi.addr = 24'h000104; mi.mem_op = 3'd2; mi.start_read = 1'b1;
    @(posedge clk); #2;
    mi.start_read = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rstn = 1'b0;
    @(negedge clk);
    check("pre_rst_cs_n", 32'(mi.spi_cs_n), 32'd0);
    @(posedge clk); #2;
    rstn = 1'b1;
    @(negedge clk);
    check("mid_rst_cs_n", 32'(mi.spi_cs_n), 32'd1);
    check("mid_rst_oe", 32'(mi.spi_data_oe), 32'd0);
    check("mid_rst_busy", 32'(mi.busy), 32'd0);
    check("mid_rst_spi_clk", 32'(mi.spi_clk), 32'd0);
    run_op(1'b0, 24'h000104, 3'd2, 32'h0, -1, 0, got);
    check("post_rst_load", got, 32'h12345678);

    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 24'($urandom_range(0, 4000));
      op = 3'($urandom_range(0, 7));
      wd = $urandom;
      exp = model_load(a, op);
      run_op(wr, a, op, wd, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1, 0, got);
      if (!wr) check($sformatf("rand%0d_load", n), got, exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tiny45_qspi_mem.md
Name: tiny45_qspi_mem

Overview:
- Memory-side responder for the Tiny45 core's nibble-serial load/store interface.
- Takes a load/store request: a 24-bit address, a `mem_op`, and a start strobe derived from the core's `address_ready`.
- Runs a QPI transaction on an external serial RAM (4-bit command, address and data).
- Loads: returns the 32-bit result to the core as 8 nibbles, low nibble first, aligned to `counter == 0`, with `load_data_ready` asserted.
- Stores: captures the 8 nibbles of store data the core presents on the 8 clocks after the start strobe.

Parameters:
- DUMMY_NIBBLES, 6, wait nibbles between address and read data.
- READ_CMD, 8'hEB, QPI read command byte.
- WRITE_CMD, 8'h38, QPI write command byte.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- addr  in  24  byte address, sampled on start_read/start_write
- mem_op  in  3  [1:0] 0=byte, 1=half, 2=word; [2]=unsigned (loads only); sampled with addr
- start_read  in  1  one-clock load request
- start_write  in  1  one-clock store request
- counter  in  3  core sub-cycle counter, increments every clock
- store_data  in  4  store nibble, low nibble first
- data_out  out  4  load result nibble to the core's data_in
- load_data_ready  out  1  data_out valid; high for exactly 8 consecutive clocks, first clock at counter==0
- busy  out  1  request in progress; starts while busy are ignored
- spi_cs_n  out  1  device select, active low
- spi_clk  out  1  device clock, clk/2
- spi_data_out  out  4  nibble to device
- spi_data_oe  out  1  drive enable for spi_data_out
- spi_data_in  in  4  nibble from device

Behaviour:
- Reset (rstn low at posedge): state IDLE; spi_cs_n=1, spi_clk=0, spi_data_oe=0, data_out=0, load_data_ready=0, busy=0.
  - Reset mid-transaction: same values next clock; partial data discarded.
- Nibble timing: each wire nibble lasts 2 clocks.
  - Controller drives spi_data_out on the clock spi_clk goes 0.
  - spi_clk is 1 on the second clock.
  - spi_data_in is sampled at the posedge that returns spi_clk to 0.
- Byte order on the wire: byte addr+0 first; within a byte, high nibble first. Command and address are sent MSB nibble first.
- States and durations:
  - IDLE: start_read → CMD. start_write → STORE_CAP. busy goes high the clock after the start. If both starts are asserted together, start_write wins.
  - STORE_CAP: 8 clocks. store_data nibble k (k=0..7, clock k+1 after start) → word bits [4k+3:4k]. Then → CMD.
  - CMD: spi_cs_n=0, oe=1, 2 nibbles of the command byte → ADDR.
  - ADDR: 6 nibbles, addr[23:20] first. Read → DUMMY; write → WDATA.
  - DUMMY: oe=0, DUMMY_NIBBLES nibbles → RDATA.
  - RDATA: 2*nbytes nibbles (nbytes = 1/2/4 from mem_op[1:0]), assembled little-endian.
    - Bytes not fetched: filled with the sign bit (bit 7 for byte, bit 15 for half) if mem_op[2]=0, otherwise zero.
    - Then → DESEL.
  - WDATA: 2*nbytes nibbles, byte 0 (word[7:0]) first, high nibble first → DESEL.
  - DESEL: spi_cs_n=1, oe=0, 2 clocks minimum deselect. Read → RESP; write → IDLE with busy=0.
  - RESP: wait for a clock with counter==0. From that clock, drive the word's nibble i on data_out with load_data_ready=1 for 8 clocks (i=0..7). Then IDLE with busy=0.
- mem_op[1:0]=3 is treated as word.
- Word read latency, DUMMY_NIBBLES=6:
  - start at clock 0; spi_cs_n low clocks 1..44; DESEL 45..46.
  - load_data_ready first high at the first clock ≥47 with counter==0.
- No alignment checks; the device handles sequential bytes across any boundary.

Decomposition:
- Shared package tiny45_mem_pkg:
  - state enum.
  - mem_op size encodings (MEM_BYTE=0, MEM_HALF=1, MEM_WORD=2).
  - QPI default command constants.
  - Function nbytes(mem_op) shared with the core.
- Optional sub-module tiny45_qspi_nibble: spi_clk phase toggle, nibble counter, drive/sample strobes. All FSM logic stays in the top module.

Test Plan:
- Word load, addr=24'h000104, device returns bytes 78 56 34 12 → wire command E,B; address nibbles 0,0,0,1,0,4; 6 dummy nibbles; data_out nibbles 8,7,6,5,4,3,2,1 starting at counter==0; load_data_ready high 8 clocks.
- Signed byte load, mem_op=0, device byte 8'h9A → core sees 32'hFFFFFF9A. Same with mem_op=4 → 32'h0000009A. Only 2 data nibbles clocked.
- Half store, mem_op=1, store_data nibbles 4,3,2,1,x,x,x,x → command 3,8; address; wire data 3,4,1,2; cs_n high after 4 data nibbles; busy clears after DESEL.
- start_read while busy during a store → ignored; no second transaction; stored bytes unchanged.
- rstn low during ADDR → next clock spi_cs_n=1, oe=0, busy=0. A subsequent load completes normally.
- Load finishing when counter==3 → load_data_ready stays low until counter==0, then exactly 8 clocks high.
